seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 4-digit multiplexed seven-segment driver on the Basys2 top level.
//  Samples the active-low seg/an/dp pins, debounces each scan slot and inverse-decodes the glyphs to hex nibbles.
//  Reassembles them into a 16-bit value, so benches and on-chip self-test can read the displayed total numerically.
// PARAMETERS
//  STABLE_CYCLES   4     consecutive identical samples of {an,seg,dp} required before a capture (>=1)
//  TIMEOUT_CYCLES  1024  cycles without a capture before a partial frame is discarded
// PORTS
//  MCLK         in   1   system clock; all logic on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  seg          in   7   segment cathodes, active-low; seg[0]=a .. seg[6]=g
//  an           in   4   digit anodes, active-low; an[3]=most-significant digit
//  dp           in   1   decimal point, active-low
//  value        out  16  last complete frame; digit k in value[4k+3:4k]
//  frame_valid  out  1   one-cycle pulse when value is updated
//  digit_seen   out  4   digits captured in the current (incomplete) frame
//  dp_bits      out  4   dp state per digit (1 = lit) for the last frame
//  decode_err   out  1   sticky error flag
// BEHAVIOUR
//  - Reset: value=0, frame_valid=0, digit_seen=0, dp_bits=0, decode_err=0.
//    Synchronisers, stability counter and timeout counter are cleared; FSM goes to IDLE.
//    Reset asserted mid-frame discards all partial data immediately.
//  - Input: {an,seg,dp} pass through a 2-FF synchroniser.
//    The sample is compared with the previous synchronised sample each cycle.
//  - Stability: if the sample differs from the previous one, the counter is set to 1.
//    Otherwise it increments, saturating at STABLE_CYCLES.
//    A capture event fires exactly on the cycle the counter reaches STABLE_CYCLES, once per stable period.
//  - Capture classification:
//    - an==4'b1111: blank; ignored, no error.
//    - an with more than one bit low: decode_err<=1; no capture.
//    - an one-hot low: seg is decoded by the exact-match table {g..a}, written as hex pattern->nibble:
//      40->0  79->1  24->2  30->3  19->4  12->5  02->6  78->7
//      00->8  10->9  08->A  03->b  46->C  21->d  06->E  0E->F
//      Any other pattern sets decode_err and does not mark the digit.
//  - FSM IDLE -> COLLECT:
//    - IDLE -> COLLECT on the first valid capture; the nibble goes to the shadow slot and its digit_seen bit is set.
//    - COLLECT:
//      - A valid capture writes its shadow slot. A repeat of an already-seen digit overwrites it (latest wins).
//      - The timeout counter clears on each valid capture.
//      - When digit_seen becomes 4'b1111, on the next cycle: value<=shadow, dp_bits<=shadow dp, frame_valid=1.
//      - digit_seen<=0 on that same cycle; the FSM returns to IDLE.
//    - COLLECT timeout (TIMEOUT_CYCLES cycles with no capture): digit_seen<=0; go to IDLE.
//      value is retained; no error is flagged.
//    - A capture on the same cycle as the timeout: the capture wins and the timeout counter clears.
//  - Latency: a pin change reaches the capture after 2 (sync) + STABLE_CYCLES cycles.
//    frame_valid follows the final digit's capture by 1 cycle.
//  - value and dp_bits change only on frame_valid cycles.
//  - decode_err clears only on reset.
// CONFIGURATION
//  - SEG7_DP_CAPTURE_EN defined: dp is synchronised alongside seg and is part of the stability compare.
//    The per-digit dp is stored and presented on dp_bits (inverted, 1 = lit).
//  - SEG7_DP_CAPTURE_EN undefined: dp is ignored (not in the stability compare) and dp_bits is tied to 4'b0000.
//    The port list is unchanged.
// TESTING
//  1. Reset pulse, then drive an=4'b1111 for 2000 cycles -> value=0, frame_valid never asserts, decode_err=0.
//  2. Scan 1,2,3,4 (an=0111/1011/1101/1110, seg=79/24/30/19), 8 cycles per slot
//     -> one frame_valid pulse, value=16'h1234, digit_seen returns to 0.
//  3. Hold each slot for STABLE_CYCLES-1 cycles only -> no capture, digit_seen stays 0, no frame_valid.
//  4. Scan digits 3 and 2 only, then blank for 1100 cycles -> digit_seen clears to 0.
//     A following full scan of A,b,C,d gives value=16'hAbCd.
//  5. seg=7'h7F on an=1110, then an=1100 -> decode_err=1 and stays 1.
//     A subsequent valid frame still updates value.
//  6. Assert reset_n=0 mid-frame after 2 digits -> all outputs 0 within the same cycle, FSM in IDLE.
//     With SEG7_DP_CAPTURE_EN, dp lit on digit 0 only -> dp_bits=4'b0001.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Receive-side decoder for a 4-digit multiplexed, active-low seven-segment
// display. The pins are synchronised, each scan slot is debounced by a
// stability counter, the glyph is inverse-decoded to a hex nibble and the four
// digits are reassembled into a 16-bit value with a one-cycle frame_valid pulse.
//
// Build option: define SEG7_DP_CAPTURE_EN to synchronise and capture the
// decimal point per digit (dp_bits, 1 = lit). Without it dp is ignored and
// dp_bits reads 4'b0000.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        MCLK,
    input  logic        reset_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic [3:0]  dp_bits,
    output logic        decode_err
);

    // Counter widths: the stability counter must hold STABLE_CYCLES and the
    // timeout counter must hold TIMEOUT_CYCLES-1.
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef SEG7_DP_CAPTURE_EN
    localparam int PW = 12;
`else
    localparam int PW = 11;
`endif

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic [PW-1:0] pins_now;

`ifdef SEG7_DP_CAPTURE_EN
    assign pins_now = {an, seg, dp};
`else
    // dp is deliberately left out of the sample so it cannot disturb
    // the stability compare.
    logic unused_dp;
    assign unused_dp = dp;
    assign pins_now  = {an, seg};
`endif

    logic [PW-1:0] sync1_reg;
    logic [PW-1:0] sync2_reg;
    logic [PW-1:0] prev_reg;

    // Two-flop synchroniser plus one delayed copy for the change compare.
    // Reset value is the idle pin level (all inactive = all ones) so the
    // post-reset sample reads as a blank slot rather than every anode lit.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
            prev_reg  <= '1;
        end else begin
            sync1_reg <= pins_now;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    logic [3:0] smp_an;
    logic [6:0] smp_seg;

    assign smp_an  = sync2_reg[PW-1 -: 4];
    assign smp_seg = sync2_reg[PW-5 -: 7];

`ifdef SEG7_DP_CAPTURE_EN
    logic smp_dp;
    assign smp_dp = sync2_reg[0];
`endif

    // ------------------------------------------------------------------
    // Stability counter and capture event
    // ------------------------------------------------------------------
    logic [SW-1:0] stab_reg;
    logic [SW-1:0] stab_next;
    logic          sample_changed;
    logic          fire;

    // Count consecutive identical samples; fire once when the count first
    // reaches STAB_MAX within a stable period.
    always_comb begin
        sample_changed = (sync2_reg != prev_reg);
        stab_next      = stab_reg;
        if (sample_changed) begin
            stab_next = SW'(1);
        end else if (stab_reg != STAB_MAX) begin
            stab_next = stab_reg + SW'(1);
        end
        fire = (stab_next == STAB_MAX) && (sample_changed || (stab_reg != STAB_MAX));
    end

    // Stability counter register.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            stab_reg <= '0;
        end else begin
            stab_reg <= stab_next;
        end
    end

    // ------------------------------------------------------------------
    // Glyph decode and capture classification
    // ------------------------------------------------------------------
    // Exact-match inverse decode of {g..a}; returns {hit, nibble}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    logic [4:0] glyph;
    logic       an_blank;
    logic       an_onehot;
    logic [3:0] cap_mask;
    logic       cap_valid;
    logic       cap_bad;

    assign glyph     = glyph_decode(smp_seg);
    assign an_blank  = (smp_an == 4'b1111);
    assign an_onehot = $onehot(~smp_an);
    // The active anode doubles as the digit_seen bit for the slot.
    assign cap_mask  = ~smp_an;
    assign cap_valid = fire && an_onehot && glyph[4];
    // Several anodes low, or one anode with an unknown glyph.
    assign cap_bad   = fire && !an_blank && !(an_onehot && glyph[4]);

    // ------------------------------------------------------------------
    // Shadow slots: latest valid capture per digit
    // ------------------------------------------------------------------
    logic [15:0] shadow_value;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  shadow_dp;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [3:0] nib_reg;

            // Latest capture for this digit wins until the frame is published.
            always_ff @(posedge MCLK or negedge reset_n) begin
                if (!reset_n) begin
                    nib_reg <= '0;
                end else if (cap_valid && cap_mask[gi]) begin
                    nib_reg <= glyph[3:0];
                end
            end

            assign shadow_value[4*gi +: 4] = nib_reg;

`ifdef SEG7_DP_CAPTURE_EN
            logic lit_reg;

            // Decimal point of the same capture, stored as 1 = lit.
            always_ff @(posedge MCLK or negedge reset_n) begin
                if (!reset_n) begin
                    lit_reg <= 1'b0;
                end else if (cap_valid && cap_mask[gi]) begin
                    lit_reg <= ~smp_dp;
                end
            end

            assign shadow_dp[gi] = lit_reg;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    state_t        state_reg;
    logic [TW-1:0] tmo_reg;
    logic [3:0]    digit_seen_reg;
    logic [15:0]   value_reg;
    logic          frame_valid_reg;
    logic          decode_err_reg;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]    dp_bits_reg;
`endif

    // Collect digits into a frame, publish once all four are seen, and drop
    // a partial frame after TIMEOUT_CYCLES without a valid capture.
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            tmo_reg         <= '0;
            digit_seen_reg  <= '0;
            value_reg       <= '0;
            frame_valid_reg <= 1'b0;
            decode_err_reg  <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_bits_reg     <= '0;
`endif
        end else begin
            frame_valid_reg <= 1'b0;
            if (cap_bad) begin
                decode_err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    tmo_reg <= '0;
                    if (cap_valid) begin
                        digit_seen_reg <= cap_mask;
                        state_reg      <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (digit_seen_reg == 4'b1111) begin
                        // All four digits present: publish the shadow frame.
                        value_reg       <= shadow_value;
`ifdef SEG7_DP_CAPTURE_EN
                        dp_bits_reg     <= shadow_dp;
`endif
                        frame_valid_reg <= 1'b1;
                        digit_seen_reg  <= '0;
                        tmo_reg         <= '0;
                        state_reg       <= IDLE;
                    end else if (cap_valid) begin
                        // A capture always beats a coincident timeout.
                        digit_seen_reg <= digit_seen_reg | cap_mask;
                        tmo_reg        <= '0;
                    end else if (tmo_reg == TMO_LAST) begin
                        // Stale partial frame: discard, keep last value.
                        digit_seen_reg <= '0;
                        tmo_reg        <= '0;
                        state_reg      <= IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign value       = value_reg;
    assign frame_valid = frame_valid_reg;
    assign digit_seen  = digit_seen_reg;
    assign decode_err  = decode_err_reg;
`ifdef SEG7_DP_CAPTURE_EN
    assign dp_bits     = dp_bits_reg;
`else
    assign dp_bits     = 4'b0000;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder: directed scan sequences, a
// table of full frames covering every glyph, and a randomized slot stream
// checked against a run-level reference model.
module tb_seg7_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

`ifdef SEG7_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        MCLK    = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg     = 7'h7F;
    logic [3:0]  an      = 4'hF;
    logic        dp      = 1'b1;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_seen;
    logic [3:0]  dp_bits;
    logic        decode_err;

    seg7_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .MCLK       (MCLK),
        .reset_n    (reset_n),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .value      (value),
        .frame_valid(frame_valid),
        .digit_seen (digit_seen),
        .dp_bits    (dp_bits),
        .decode_err (decode_err)
    );

    always #5 MCLK = ~MCLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] glyph_tbl [16];

    // ---------------- monitor ----------------
    int          frames_seen = 0;
    int          glitches    = 0;
    logic [15:0] last_value  = 16'h0;
    logic [3:0]  last_dp     = 4'h0;
    logic        fv_prev     = 1'b0;
    logic [15:0] fr_val_q [$];
    logic [3:0]  fr_dp_q  [$];

    always @(negedge MCLK) begin
        if (frame_valid === 1'b1) begin
            frames_seen++;
            fr_val_q.push_back(value);
            fr_dp_q.push_back(dp_bits);
            if (fv_prev === 1'b1) glitches++;
        end else if (reset_n && (value !== last_value || dp_bits !== last_dp)) begin
            glitches++;
        end
        last_value = value;
        last_dp    = dp_bits;
        fv_prev    = frame_valid;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_dp(input logic [3:0] lit);
        return DP_EN ? lit : 4'b0000;
    endfunction

    task automatic hold_pins(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    // Scan digit 3 down to 0; gl = {g3,g2,g1,g0}, dpn = active-low dp per digit.
    task automatic scan_frame(input logic [27:0] gl, input logic [3:0] dpn, input int hold);
        for (int k = 3; k >= 0; k--) begin
            logic [3:0] a;
            a    = 4'b1111;
            a[k] = 1'b0;
            hold_pins(a, gl[7*k +: 7], dpn[k], hold);
        end
    endtask

    task automatic blank(input int n);
        hold_pins(4'hF, 7'h7F, 1'b1, n);
    endtask

    task automatic do_reset();
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge MCLK);
            #1;
        end
        reset_n = 1'b1;
    endtask

    function automatic logic [27:0] glyphs4(input int d3, input int d2, input int d1, input int d0);
        return {glyph_tbl[d3], glyph_tbl[d2], glyph_tbl[d1], glyph_tbl[d0]};
    endfunction

    // ---------------- reference model (run level) ----------------
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         hold;
    } slot_t;

    logic [3:0]  m_seen;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_lit;
    int          m_last;
    bit          m_err;
    logic [15:0] exp_val_q [$];
    logic [3:0]  exp_dp_q  [$];

    function automatic int glyph_lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyph_tbl[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic logic [11:0] pin_key(input slot_t x);
        return DP_EN ? {x.an, x.seg, x.dp} : {x.an, x.seg, 1'b0};
    endfunction

    // A run of identical pins lasting at least STABLE cycles yields one capture.
    task automatic model_run(input slot_t x, input int start, input int len);
        int tc;
        int idx;
        int k;
        if (len < STABLE) return;
        tc = start + STABLE;
        if (x.an == 4'hF) return;
        if ($countones(~x.an) > 1) begin
            m_err = 1'b1;
            return;
        end
        idx = glyph_lookup(x.seg);
        if (idx < 0) begin
            m_err = 1'b1;
            return;
        end
        k = 0;
        for (int i = 0; i < 4; i++) if (x.an[i] == 1'b0) k = i;
        if (m_seen != 4'h0 && (tc - m_last) > TIMEOUT) m_seen = 4'h0;
        m_seen[k] = 1'b1;
        m_nib[k]  = 4'(idx);
        m_lit[k]  = ~x.dp;
        m_last    = tc;
        if (m_seen == 4'hF) begin
            exp_val_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
            exp_dp_q.push_back(m_lit);
            m_seen = 4'h0;
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [27:0] gl;
        logic [3:0]  dpn;
        logic [15:0] exp_val;
        logic [3:0]  exp_lit;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int fs;
        slot_t slots [$];
        slot_t s;
        int t, rs, rl, nmin;
        slot_t cur;

        glyph_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{gl: glyphs4(0, 1, 2, 3),    dpn: 4'b1111, exp_val: 16'h0123, exp_lit: 4'b0000};
        vecs[1] = '{gl: glyphs4(4, 5, 6, 7),    dpn: 4'b0101, exp_val: 16'h4567, exp_lit: 4'b1010};
        vecs[2] = '{gl: glyphs4(8, 9, 10, 11),  dpn: 4'b1110, exp_val: 16'h89AB, exp_lit: 4'b0001};
        vecs[3] = '{gl: glyphs4(12, 13, 14, 15), dpn: 4'b0000, exp_val: 16'hCDEF, exp_lit: 4'b1111};

        // Reset state, sampled while reset is held.
        repeat (2) begin
            @(posedge MCLK);
            #1;
        end
        check("rst_value", 32'(value), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_digit_seen", 32'(digit_seen), 32'h0);
        check("rst_dp_bits", 32'(dp_bits), 32'h0);
        check("rst_decode_err", 32'(decode_err), 32'h0);
        reset_n = 1'b1;

        // 1. Blank for 2000 cycles.
        blank(2000);
        check("blank_value", 32'(value), 32'h0);
        check("blank_frames", 32'(frames_seen), 32'h0);
        check("blank_err", 32'(decode_err), 32'h0);

        // 2. Scan 1,2,3,4.
        fs = frames_seen;
        scan_frame(glyphs4(1, 2, 3, 4), 4'b1111, 8);
        blank(10);
        check("scan1234_frames", 32'(frames_seen - fs), 32'd1);
        check("scan1234_value", 32'(value), 32'h1234);
        check("scan1234_seen", 32'(digit_seen), 32'h0);
        check("scan1234_dp", 32'(dp_bits), 32'(exp_dp(4'b0000)));

        // 3. Slots held only STABLE-1 cycles: never captured.
        fs = frames_seen;
        scan_frame(glyphs4(5, 6, 7, 8), 4'b1111, STABLE - 1);
        scan_frame(glyphs4(5, 6, 7, 8), 4'b1111, STABLE - 1);
        check("short_seen", 32'(digit_seen), 32'h0);
        blank(10);
        check("short_frames", 32'(frames_seen - fs), 32'd0);
        check("short_value", 32'(value), 32'h1234);

        // 4. Partial frame then timeout; then a full frame.
        fs = frames_seen;
        hold_pins(4'b0111, glyph_tbl[3], 1'b1, 8);
        hold_pins(4'b1011, glyph_tbl[2], 1'b1, 8);
        check("partial_seen", 32'(digit_seen), 32'hC);
        blank(1100);
        check("timeout_seen", 32'(digit_seen), 32'h0);
        check("timeout_frames", 32'(frames_seen - fs), 32'd0);
        check("timeout_value", 32'(value), 32'h1234);
        check("timeout_err", 32'(decode_err), 32'h0);
        scan_frame(glyphs4(10, 11, 12, 13), 4'b1111, 8);
        blank(10);
        check("abcd_value", 32'(value), 32'hABCD);

        // Gap shorter than the timeout keeps the partial frame alive.
        hold_pins(4'b0111, glyph_tbl[5], 1'b1, 8);
        hold_pins(4'b1011, glyph_tbl[6], 1'b1, 8);
        blank(900);
        check("gap_seen", 32'(digit_seen), 32'hC);
        hold_pins(4'b1101, glyph_tbl[7], 1'b1, 8);
        hold_pins(4'b1110, glyph_tbl[8], 1'b1, 8);
        blank(10);
        check("gap_value", 32'(value), 32'h5678);

        // 5. Bad glyph, then two anodes low.
        hold_pins(4'b1110, 7'h7F, 1'b1, 8);
        check("badglyph_err", 32'(decode_err), 32'h1);
        check("badglyph_seen", 32'(digit_seen), 32'h0);
        hold_pins(4'b1100, glyph_tbl[1], 1'b1, 8);
        blank(10);
        check("multi_an_err", 32'(decode_err), 32'h1);
        check("multi_an_seen", 32'(digit_seen), 32'h0);
        scan_frame(glyphs4(9, 8, 7, 6), 4'b1111, 8);
        blank(10);
        check("after_err_value", 32'(value), 32'h9876);
        check("err_sticky", 32'(decode_err), 32'h1);

        // 6. Asynchronous reset mid-frame.
        hold_pins(4'b0111, glyph_tbl[14], 1'b1, 8);
        hold_pins(4'b1011, glyph_tbl[15], 1'b1, 8);
        check("mid_seen", 32'(digit_seen), 32'hC);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_value", 32'(value), 32'h0);
        check("async_rst_seen", 32'(digit_seen), 32'h0);
        check("async_rst_err", 32'(decode_err), 32'h0);
        check("async_rst_fv", 32'(frame_valid), 32'h0);
        check("async_rst_dp", 32'(dp_bits), 32'h0);
        do_reset();
        blank(10);
        scan_frame(glyphs4(1, 2, 3, 4), 4'b1110, 8);
        blank(10);
        check("dp0_value", 32'(value), 32'h1234);
        check("dp0_bits", 32'(dp_bits), 32'(exp_dp(4'b0001)));
        check("dp0_err", 32'(decode_err), 32'h0);

        // Table: every glyph, several dp patterns.
        for (int v = 0; v < 4; v++) begin
            fs = frames_seen;
            scan_frame(vecs[v].gl, vecs[v].dpn, 6 + v);
            blank(10);
            check($sformatf("tbl%0d_frames", v), 32'(frames_seen - fs), 32'd1);
            check($sformatf("tbl%0d_value", v), 32'(value), 32'(vecs[v].exp_val));
            check($sformatf("tbl%0d_dp", v), 32'(dp_bits), 32'(exp_dp(vecs[v].exp_lit)));
        end

        // Randomized slot stream against the run-level model.
        do_reset();
        blank(10);
        fr_val_q.delete();
        fr_dp_q.delete();

        s.an = 4'b0111; s.seg = glyph_tbl[3]; s.dp = 1'b1; s.hold = 8;
        slots.push_back(s);
        for (int i = 1; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                s.an = 4'hF;
                s.an[$urandom_range(0, 3)] = 1'b0;
            end else if (r == 7) begin
                s.an = 4'hF;
            end else begin
                do s.an = 4'($urandom_range(0, 14)); while ($countones(~s.an) < 2);
            end
            if ($urandom_range(0, 99) < 85) s.seg = glyph_tbl[$urandom_range(0, 15)];
            else s.seg = 7'($urandom_range(0, 127));
            s.dp   = 1'($urandom_range(0, 1));
            s.hold = int'($urandom_range(1, 10));
            slots.push_back(s);
        end
        s.an = 4'hF; s.seg = 7'h7F; s.dp = 1'b1; s.hold = 40;
        slots.push_back(s);

        m_seen = 4'h0; m_lit = 4'h0; m_last = 0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        t = 0; rs = 0; rl = 0;
        cur = slots[0];
        foreach (slots[i]) begin
            if (i != 0 && pin_key(slots[i]) == pin_key(cur)) begin
                rl += slots[i].hold;
            end else begin
                if (i != 0) model_run(cur, rs, rl);
                cur = slots[i];
                rs  = t;
                rl  = slots[i].hold;
            end
            t += slots[i].hold;
        end
        model_run(cur, rs, rl);
        if (m_seen != 4'h0 && (t - m_last) > TIMEOUT) m_seen = 4'h0;

        foreach (slots[i]) hold_pins(slots[i].an, slots[i].seg, slots[i].dp, slots[i].hold);

        check("rand_frame_count", 32'(fr_val_q.size()), 32'(exp_val_q.size()));
        nmin = (fr_val_q.size() < exp_val_q.size()) ? fr_val_q.size() : exp_val_q.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("rand_frame%0d_value", i), 32'(fr_val_q[i]), 32'(exp_val_q[i]));
            check($sformatf("rand_frame%0d_dp", i), 32'(fr_dp_q[i]), 32'(exp_dp(exp_dp_q[i])));
        end
        check("rand_digit_seen", 32'(digit_seen), 32'(m_seen));
        check("rand_decode_err", 32'(decode_err), 32'(m_err));

        check("value_stable_between_frames", 32'(glitches), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
